// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with DECODE (valid/ready) and SCAN (auto-walk) modes.
// Define DEC_ACTIVE_LOW_EN to drive y active-low (selected line 0, idle all-ones).
module decoder_nto2n_seq #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   sel_valid,
  input  logic [SEL_W-1:0]       sel,
  output logic                   sel_ready,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [(2**SEL_W)-1:0]  y,
  output logic                   y_valid,
  output logic [SEL_W-1:0]       idx,
  output logic                   wrap
);
  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t              r_state;
  logic [OUT_W-1:0]    r_y;
  logic                r_y_valid;
  logic [SEL_W-1:0]    r_idx;
  logic                r_wrap;
  logic [DWELL_W-1:0]  r_cnt;
  logic [DWELL_W-1:0]  r_dwell;

  state_t              w_state_next;
  logic [OUT_W-1:0]    w_y_next;
  logic                w_y_valid_next;
  logic [SEL_W-1:0]    w_idx_next;
  logic                w_wrap_next;
  logic [DWELL_W-1:0]  w_cnt_next;
  logic [DWELL_W-1:0]  w_dwell_next;
  logic [OUT_W-1:0]    w_sel_onehot;
  logic                w_handshake;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign w_sel_onehot[gi] = (sel == SEL_W'(gi));
    end
  endgenerate

  assign sel_ready   = (r_state == ST_DEC) && en && !mode;
  assign w_handshake = sel_valid && sel_ready;

  always_comb begin
    w_state_next   = r_state;
    w_y_next       = r_y;
    w_y_valid_next = r_y_valid;
    w_idx_next     = r_idx;
    w_wrap_next    = 1'b0;
    w_cnt_next     = r_cnt;
    w_dwell_next   = r_dwell;

    if (!en) begin
      w_state_next   = ST_IDLE;
      w_y_next       = '0;
      w_y_valid_next = 1'b0;
      w_cnt_next     = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DEC: begin
          if (mode) begin
            // Scan always starts from line 0 with a freshly latched dwell.
            w_state_next   = ST_SCAN;
            w_y_next       = OUT_W'(1);
            w_idx_next     = '0;
            w_y_valid_next = 1'b1;
            w_cnt_next     = '0;
            w_dwell_next   = dwell;
          end else if (r_state == ST_IDLE) begin
            w_state_next = ST_DEC;
          end else if (w_handshake) begin
            w_y_next       = w_sel_onehot;
            w_idx_next     = sel;
            w_y_valid_next = 1'b1;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            w_state_next = ST_DEC;
            w_cnt_next   = '0;
          end else if (r_cnt == r_dwell) begin
            w_cnt_next   = '0;
            w_idx_next   = r_idx + SEL_W'(1);
            w_y_next     = {r_y[OUT_W-2:0], r_y[OUT_W-1]};
            w_dwell_next = dwell;
            w_wrap_next  = &r_idx;
          end else begin
            w_cnt_next = r_cnt + DWELL_W'(1);
          end
        end
        default: begin
          w_state_next   = ST_IDLE;
          w_y_next       = '0;
          w_y_valid_next = 1'b0;
          w_cnt_next     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_idx     <= '0;
      r_wrap    <= 1'b0;
      r_cnt     <= '0;
      r_dwell   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_y       <= w_y_next;
      r_y_valid <= w_y_valid_next;
      r_idx     <= w_idx_next;
      r_wrap    <= w_wrap_next;
      r_cnt     <= w_cnt_next;
      r_dwell   <= w_dwell_next;
    end
  end

`ifdef DEC_ACTIVE_LOW_EN
  assign y = ~r_y;
`else
  assign y = r_y;
`endif
  assign y_valid = r_y_valid;
  assign idx     = r_idx;
  assign wrap    = r_wrap;

endmodule
